// File: rtl/prog_loader_pkg.sv
// Shared constants for the boot-time program loader: FSM encoding and word geometry.
package prog_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned ByteCntW       = $clog2(BYTES_PER_WORD);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRecv  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Assembles big-endian bytes into 32-bit words; word_ready_o flags the byte that completes a word.
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [ByteCntW-1:0] cnt_q, cnt_d;
  logic [31:0]         word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (shift_i) begin
      cnt_d  = cnt_q + ByteCntW'(1);
      word_d = {word_q[23:0], byte_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o       = word_q;
  assign word_ready_o = shift_i && !clear_i && (cnt_q == ByteCntW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Streams a byte-serial program image into instruction memory while holding the CPU in reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              abort_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [31:0]       mem_d_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       checksum_o
);

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       checksum_q, checksum_d;
  logic              hold_q, hold_d;

  logic              pk_clear;
  logic              pk_shift;
  logic [31:0]       pk_word;
  logic              pk_word_ready;
  logic [LEN_W-1:0]  words_written;

  assign pk_shift      = in_valid_i && in_ready_o;
  assign words_written = LEN_W'(addr_q) + LEN_W'(1);

  prog_loader_byte_packer u_byte_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (pk_clear),
    .shift_i      (pk_shift),
    .byte_i       (in_data_i),
    .word_o       (pk_word),
    .word_ready_o (pk_word_ready)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    checksum_d = checksum_q;
    hold_d     = hold_q;
    pk_clear   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i && (len_i != '0)) begin
          state_d    = StRecv;
          len_d      = len_i;
          addr_d     = '0;
          checksum_d = '0;
          hold_d     = 1'b1;
          pk_clear   = 1'b1;
        end
      end
      StRecv: begin
        if (abort_i) begin
          state_d = StIdle;
          hold_d  = 1'b0;
        end else if (pk_word_ready) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        // Abort wins over the pending write: no strobe, no checksum update.
        if (abort_i) begin
          state_d = StIdle;
          hold_d  = 1'b0;
        end else begin
          checksum_d = checksum_q + pk_word;
          if (words_written == len_q) begin
            state_d = StDone;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StRecv;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        hold_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        hold_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      addr_q     <= '0;
      checksum_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      checksum_q <= checksum_d;
      hold_q     <= hold_d;
    end
  end

  assign in_ready_o = (state_q == StRecv);
  assign mem_we_o   = (state_q == StWrite) && !abort_i;
  assign mem_a_o    = addr_q;
  assign mem_d_o    = (state_q == StWrite) ? pk_word : 32'h0;
  assign cpu_hold_o = hold_q;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StDone);
  assign checksum_o = checksum_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; writes and done pulses are logged on the falling edge.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LEN_W  = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [LEN_W-1:0]  len_i = '0;
  logic              abort_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic [7:0]        in_data_i = '0;
  logic              in_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_a_o;
  logic [31:0]       mem_d_o;
  logic              cpu_hold_o;
  logic              busy_o;
  logic              done_o;
  logic [31:0]       checksum_o;

  int checks = 0;
  int errors = 0;
  int wr_n   = 0;
  int done_n = 0;
  int base_w;
  int base_d;
  logic [7:0]  wr_a [64];
  logic [31:0] wr_d [64];

  always #5 clk = ~clk;

  prog_loader #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .len_i      (len_i),
    .abort_i    (abort_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (in_ready_o),
    .mem_we_o   (mem_we_o),
    .mem_a_o    (mem_a_o),
    .mem_d_o    (mem_d_o),
    .cpu_hold_o (cpu_hold_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .checksum_o (checksum_o)
  );

  always @(negedge clk) begin
    if (mem_we_o && wr_n < 64) begin
      wr_a[wr_n] = mem_a_o;
      wr_d[wr_n] = mem_d_o;
      wr_n++;
    end
    if (done_o) done_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [LEN_W-1:0] n);
    start_i = 1'b1;
    len_i   = n;
    step();
    start_i = 1'b0;
    len_i   = '0;
  endtask

  // Present one byte and hold it until the handshake edge has passed.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid_i = 1'b1;
    in_data_i  = b;
    while (!in_ready_o && n < 50) begin
      step();
      n++;
    end
    check("in_ready_wait", {31'b0, in_ready_o}, 32'h1);
    step();
    in_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    check("rst_busy", {31'b0, busy_o}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready_o}, 32'h0);
    check("rst_hold", {31'b0, cpu_hold_o}, 32'h0);
    check("rst_checksum", checksum_o, 32'h0);
    step();
    rst = 1'b0;
    step();

    // Two-word load with latency checks
    base_w = wr_n;
    base_d = done_n;
    start_load(9'd2);
    check("t1_busy", {31'b0, busy_o}, 32'h1);
    check("t1_hold", {31'b0, cpu_hold_o}, 32'h1);
    check("t1_ready", {31'b0, in_ready_o}, 32'h1);
    send_word(32'h20080005);
    check("t1_we0", {31'b0, mem_we_o}, 32'h1);
    check("t1_a0", {24'b0, mem_a_o}, 32'h0);
    check("t1_d0", mem_d_o, 32'h20080005);
    check("t1_ready_in_write", {31'b0, in_ready_o}, 32'h0);
    send_word(32'h3C011234);
    check("t1_we1", {31'b0, mem_we_o}, 32'h1);
    check("t1_a1", {24'b0, mem_a_o}, 32'h1);
    check("t1_d1", mem_d_o, 32'h3C011234);
    step();
    check("t1_done", {31'b0, done_o}, 32'h1);
    check("t1_hold_in_done", {31'b0, cpu_hold_o}, 32'h1);
    check("t1_checksum", checksum_o, 32'h5C091239);
    step();
    check("t1_done_pulse", {31'b0, done_o}, 32'h0);
    check("t1_idle_busy", {31'b0, busy_o}, 32'h0);
    check("t1_idle_hold", {31'b0, cpu_hold_o}, 32'h0);
    check("t1_nwrites", wr_n - base_w, 32'd2);
    check("t1_ndone", done_n - base_d, 32'd1);
    check("t1_log_d0", wr_d[base_w], 32'h20080005);
    check("t1_log_a1", {24'b0, wr_a[base_w+1]}, 32'h1);

    // Zero-length start is ignored
    base_d = done_n;
    start_load(9'd0);
    check("t2_busy", {31'b0, busy_o}, 32'h0);
    check("t2_hold", {31'b0, cpu_hold_o}, 32'h0);
    check("t2_ready", {31'b0, in_ready_o}, 32'h0);
    step();
    check("t2_ndone", done_n - base_d, 32'd0);

    // One word with in_valid gaps; a stray start mid-load must not change len
    base_w = wr_n;
    base_d = done_n;
    start_load(9'd1);
    send_byte(8'hFF);
    step();
    start_i = 1'b1;
    len_i   = 9'd5;
    send_byte(8'hFF);
    start_i = 1'b0;
    len_i   = '0;
    step();
    send_byte(8'hFF);
    step();
    check("t3_stall_busy", {31'b0, busy_o}, 32'h1);
    send_byte(8'hFF);
    check("t3_we", {31'b0, mem_we_o}, 32'h1);
    check("t3_a", {24'b0, mem_a_o}, 32'h0);
    check("t3_d", mem_d_o, 32'hFFFFFFFF);
    step();
    check("t3_done", {31'b0, done_o}, 32'h1);
    check("t3_checksum", checksum_o, 32'hFFFFFFFF);
    step();
    check("t3_nwrites", wr_n - base_w, 32'd1);
    check("t3_ndone", done_n - base_d, 32'd1);

    // Abort in RECV after six bytes of a three-word load
    base_w = wr_n;
    base_d = done_n;
    start_load(9'd3);
    send_word(32'h11223344);
    send_byte(8'h55);
    send_byte(8'h66);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("t4_busy", {31'b0, busy_o}, 32'h0);
    check("t4_hold", {31'b0, cpu_hold_o}, 32'h0);
    check("t4_ready", {31'b0, in_ready_o}, 32'h0);
    check("t4_checksum", checksum_o, 32'h11223344);
    step();
    check("t4_nwrites", wr_n - base_w, 32'd1);
    check("t4_ndone", done_n - base_d, 32'd0);
    check("t4_log_d", wr_d[base_w], 32'h11223344);

    // Abort during WRITE suppresses the strobe
    base_w = wr_n;
    start_load(9'd2);
    send_word(32'hAABBCCDD);
    abort_i = 1'b1;
    #1;
    check("t5_we_suppressed", {31'b0, mem_we_o}, 32'h0);
    step();
    abort_i = 1'b0;
    check("t5_busy", {31'b0, busy_o}, 32'h0);
    check("t5_checksum", checksum_o, 32'h0);
    check("t5_nwrites", wr_n - base_w, 32'd0);

    // Asynchronous reset during the second byte, then a clean load
    base_w = wr_n;
    start_load(9'd1);
    send_byte(8'h01);
    in_valid_i = 1'b1;
    in_data_i  = 8'h02;
    #2;
    rst = 1'b1;
    #1;
    check("t6_busy", {31'b0, busy_o}, 32'h0);
    check("t6_hold", {31'b0, cpu_hold_o}, 32'h0);
    check("t6_ready", {31'b0, in_ready_o}, 32'h0);
    check("t6_we", {31'b0, mem_we_o}, 32'h0);
    check("t6_d", mem_d_o, 32'h0);
    step();
    rst = 1'b0;
    in_valid_i = 1'b0;
    repeat (3) step();
    check("t6_nwrites", wr_n - base_w, 32'd0);
    base_d = done_n;
    start_load(9'd1);
    send_word(32'h00000001);
    check("t6_a", {24'b0, mem_a_o}, 32'h0);
    check("t6_d_clean", mem_d_o, 32'h00000001);
    step();
    check("t6_done", {31'b0, done_o}, 32'h1);
    step();
    check("t6_ndone", done_n - base_d, 32'd1);

    // Checksum wrap-around
    start_load(9'd2);
    send_word(32'hFFFFFFFF);
    send_word(32'h00000002);
    step();
    check("t7_done", {31'b0, done_o}, 32'h1);
    check("t7_checksum", checksum_o, 32'h00000001);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
